datapath: RTL and testbench
===========================

Name: datapath

Overview:
- 32-bit single-bus CPU datapath for the phase-1 processor.
- Contains registers R1/R6/R7, PC, IR, MAR, MDR, Y and a 64-bit Z, plus a small ALU, all joined by one bus multiplexer.
- An external control sequencer (later a control unit) drives one-hot "out" strobes onto the bus and "in" strobes to load registers.
- Memory read data arrives on Mdatain; MAR supplies the address.

Parameters:
- WIDTH, 32, width of the bus, registers and ALU operands.
- PC_INC, 1, constant added to the bus by IncPC.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- Mdatain  in  32  memory read data.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- PCout, Zlowout, Zhighout, MDRout, R1out, R6out, R7out  in  1 each  bus source strobes.
- PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R6in, R7in  in  1 each  register load strobes.
- IncPC, AND  in  1 each  ALU operation strobes.
- BusMuxOut  out  32  current bus value.
- MAR_q, IR_q, R1_q, R6_q, R7_q  out  32 each  register contents.
- Zlow_q  out  32  Z[31:0].

Behaviour:
- Reset: clear low asynchronously forces every register (PC, IR, MAR, MDR, Y, Z, R1, R6, R7) to 0. All outputs then read 0.
- Bus source selection uses fixed priority: MDRout > Zlowout > Zhighout > PCout > R7out > R6out > R1out.
  - With no strobe asserted, BusMuxOut = 0.
  - The bus is purely combinational.
- Register loads:
  - Each xxin strobe loads that register from BusMuxOut on the rising edge. Otherwise the register holds.
  - MDR loads when MDRin = 1, taking Mdatain if Read = 1, else BusMuxOut.
- Same-cycle read/write: a register may be driven onto the bus and loaded in the same cycle. It captures the pre-edge bus value, so there is no combinational loop.
- ALU (combinational, A = Y, B = BusMuxOut):
  - AND: result = {32'b0, Y & B}.
  - IncPC: result = {32'b0, B + PC_INC}, wrapping mod 2^32.
  - If both AND and IncPC are asserted, AND wins.
  - With no op asserted, result = {32'b0, B} (pass-through).
- Z load:
  - Z loads the ALU result on the rising edge when Zin = 1 OR any op strobe (AND, IncPC) = 1.
  - Zlowout drives Z[31:0]; Zhighout drives Z[63:32].
- Latency: register-to-register transfer takes 1 cycle. ALU operation to Z takes 1 cycle, then Z to destination takes 1 more cycle.
- Reset mid-operation: all state clears immediately. The first edge after clear rises behaves as from power-up.
- Sizing: no memory, no FSM inside the block. Sequencing is entirely external.

Optional Feature:
- DATAPATH_NEG_EN:
  - When defined, adds input port NEG (1 bit). NEG selects ALU result = {32'b0, (~B) + 1} (two's complement of the bus).
  - Priority among ops: AND > NEG > IncPC. NEG also triggers a Z load.
  - When undefined, the port and logic are absent.

Decomposition:
- Package datapath_pkg holds:
  - WIDTH default
  - bus-source priority encoding (localparam one-hot indices)
  - ALU op enum (OP_PASS, OP_AND, OP_INC, OP_NEG)
- One natural sub-module, dp_reg: WIDTH-bit register with load enable and asynchronous active-low clear. Instantiated for every architectural register; Z uses two instances.

Test Plan:
- Reset: hold clear = 0, pulse strobes → all *_q = 0 and BusMuxOut = 0. Release clear → values still 0.
- Register load:
  - Mdatain = 0x12, Read = 1, MDRin = 1 for one edge; then MDRout = 1, R6in = 1 → R6_q = 0x12.
  - Repeat with 0x10 → R7, and 0x18 → R1.
- PC increment: PC = 0. PCout, IncPC, MARin asserted → MAR_q = 0 and Zlow_q = 1. Next cycle Zlowout + PCin → PC = 1.
- Instruction fetch: Mdatain = 0x4, Read + MDRin, then MDRout + IRin → IR_q = 0x00000004.
- AND:
  - Load Y from R7 (0x10). Then R6out + AND → Zlow_q = 0x12 & 0x10 = 0x10.
  - Then Zlowout + R6in → R6_q = 0x10, while R1_q stays 0x18.
- Bus priority: MDRout and R7out asserted together → BusMuxOut = MDR value. No strobes → BusMuxOut = 0.
- With DATAPATH_NEG_EN: R1 = 0x18, R1out + NEG → Zlow_q = 0xFFFFFFE8.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths, bus-source indices and ALU op encoding.
// Optional NEG op is enabled by DATAPATH_NEG_EN.
package datapath_pkg;

  localparam int DP_WIDTH = 32;

  localparam int N_SRC   = 7;
  localparam int SRC_R1  = 0;
  localparam int SRC_R6  = 1;
  localparam int SRC_R7  = 2;
  localparam int SRC_PC  = 3;
  localparam int SRC_ZHI = 4;
  localparam int SRC_ZLO = 5;
  localparam int SRC_MDR = 6;

  typedef enum logic [1:0] {
    OP_PASS,
    OP_AND,
    OP_INC,
    OP_NEG
  } alu_op_e;

  function automatic alu_op_e alu_sel(
    input logic i_and,
    input logic i_neg,
    input logic i_inc
  );
    if (i_and)      return OP_AND;
    else if (i_neg) return OP_NEG;
    else if (i_inc) return OP_INC;
    else            return OP_PASS;
  endfunction

endpackage

// File: rtl/dp_reg.sv
// dp_reg: WIDTH-bit load-enable register, async active-low clear.
// Building block for every architectural register in datapath.
module dp_reg
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/datapath.sv
// datapath: single-bus CPU datapath with priority bus mux and small ALU.
// Define DATAPATH_NEG_EN to add the NEG port and two's-complement op.
module datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH  = DP_WIDTH,
  parameter int PC_INC = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             Read,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             Zhighout,
  input  logic             MDRout,
  input  logic             R1out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             R1in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             IncPC,
`ifdef DATAPATH_NEG_EN
  input  logic             NEG,
`endif
  input  logic             AND,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] MAR_q,
  output logic [WIDTH-1:0] IR_q,
  output logic [WIDTH-1:0] R1_q,
  output logic [WIDTH-1:0] R6_q,
  output logic [WIDTH-1:0] R7_q,
  output logic [WIDTH-1:0] Zlow_q
);

  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] r_pc, r_ir, r_mar, r_mdr;
  logic [WIDTH-1:0] r_y, r_zlo, r_zhi;
  logic [WIDTH-1:0] r_r1, r_r6, r_r7;
  logic [WIDTH-1:0] w_mdr_d;
  logic [WIDTH-1:0] w_alu_lo;
  logic [WIDTH-1:0] w_alu_hi;
  logic [N_SRC-1:0] w_src;
  logic             w_neg;
  logic             w_zld;
  alu_op_e          w_op;

`ifdef DATAPATH_NEG_EN
  assign w_neg = NEG;
`else
  assign w_neg = 1'b0;
`endif

  assign w_src[SRC_R1]  = R1out;
  assign w_src[SRC_R6]  = R6out;
  assign w_src[SRC_R7]  = R7out;
  assign w_src[SRC_PC]  = PCout;
  assign w_src[SRC_ZHI] = Zhighout;
  assign w_src[SRC_ZLO] = Zlowout;
  assign w_src[SRC_MDR] = MDRout;

  // Ordered case arms give the fixed source priority.
  always_comb begin
    w_bus = '0;
    case (1'b1)
      w_src[SRC_MDR]: w_bus = r_mdr;
      w_src[SRC_ZLO]: w_bus = r_zlo;
      w_src[SRC_ZHI]: w_bus = r_zhi;
      w_src[SRC_PC]:  w_bus = r_pc;
      w_src[SRC_R7]:  w_bus = r_r7;
      w_src[SRC_R6]:  w_bus = r_r6;
      w_src[SRC_R1]:  w_bus = r_r1;
      default:        w_bus = '0;
    endcase
  end

  assign w_op = alu_sel(AND, w_neg, IncPC);

  always_comb begin
    w_alu_lo = w_bus;
    unique case (w_op)
      OP_AND:  w_alu_lo = r_y & w_bus;
      OP_INC:  w_alu_lo = w_bus + WIDTH'(PC_INC);
`ifdef DATAPATH_NEG_EN
      OP_NEG:  w_alu_lo = (~w_bus) + WIDTH'(1);
`endif
      default: w_alu_lo = w_bus;
    endcase
  end

  assign w_alu_hi = '0;
  assign w_zld    = Zin | AND | IncPC | w_neg;
  assign w_mdr_d  = Read ? Mdatain : w_bus;

  dp_reg #(.WIDTH(WIDTH)) u_pc (
    .i_clk(clock), .i_rst_n(clear), .i_ld(PCin),
    .i_d(w_bus), .o_q(r_pc)
  );
  dp_reg #(.WIDTH(WIDTH)) u_ir (
    .i_clk(clock), .i_rst_n(clear), .i_ld(IRin),
    .i_d(w_bus), .o_q(r_ir)
  );
  dp_reg #(.WIDTH(WIDTH)) u_mar (
    .i_clk(clock), .i_rst_n(clear), .i_ld(MARin),
    .i_d(w_bus), .o_q(r_mar)
  );
  dp_reg #(.WIDTH(WIDTH)) u_mdr (
    .i_clk(clock), .i_rst_n(clear), .i_ld(MDRin),
    .i_d(w_mdr_d), .o_q(r_mdr)
  );
  dp_reg #(.WIDTH(WIDTH)) u_y (
    .i_clk(clock), .i_rst_n(clear), .i_ld(Yin),
    .i_d(w_bus), .o_q(r_y)
  );
  dp_reg #(.WIDTH(WIDTH)) u_zlo (
    .i_clk(clock), .i_rst_n(clear), .i_ld(w_zld),
    .i_d(w_alu_lo), .o_q(r_zlo)
  );
  dp_reg #(.WIDTH(WIDTH)) u_zhi (
    .i_clk(clock), .i_rst_n(clear), .i_ld(w_zld),
    .i_d(w_alu_hi), .o_q(r_zhi)
  );
  dp_reg #(.WIDTH(WIDTH)) u_r1 (
    .i_clk(clock), .i_rst_n(clear), .i_ld(R1in),
    .i_d(w_bus), .o_q(r_r1)
  );
  dp_reg #(.WIDTH(WIDTH)) u_r6 (
    .i_clk(clock), .i_rst_n(clear), .i_ld(R6in),
    .i_d(w_bus), .o_q(r_r6)
  );
  dp_reg #(.WIDTH(WIDTH)) u_r7 (
    .i_clk(clock), .i_rst_n(clear), .i_ld(R7in),
    .i_d(w_bus), .o_q(r_r7)
  );

  assign BusMuxOut = w_bus;
  assign MAR_q     = r_mar;
  assign IR_q      = r_ir;
  assign R1_q      = r_r1;
  assign R6_q      = r_r6;
  assign R7_q      = r_r7;
  assign Zlow_q    = r_zlo;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed vector table plus reset and NEG sequences.
// Define DATAPATH_NEG_EN to also exercise the NEG op.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] Mdatain = '0;
  logic        Read = 1'b0;
  logic        PCout = 1'b0, Zlowout = 1'b0, Zhighout = 1'b0;
  logic        MDRout = 1'b0, R1out = 1'b0, R6out = 1'b0, R7out = 1'b0;
  logic        PCin = 1'b0, IRin = 1'b0, MARin = 1'b0, MDRin = 1'b0;
  logic        Yin = 1'b0, Zin = 1'b0;
  logic        R1in = 1'b0, R6in = 1'b0, R7in = 1'b0;
  logic        IncPC = 1'b0, AND = 1'b0, NEG = 1'b0;
  logic [31:0] BusMuxOut, MAR_q, IR_q, R1_q, R6_q, R7_q, Zlow_q;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .R1out(R1out), .R6out(R6out), .R7out(R7out),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .R1in(R1in), .R6in(R6in), .R7in(R7in),
    .IncPC(IncPC),
`ifdef DATAPATH_NEG_EN
    .NEG(NEG),
`endif
    .AND(AND),
    .BusMuxOut(BusMuxOut), .MAR_q(MAR_q), .IR_q(IR_q),
    .R1_q(R1_q), .R6_q(R6_q), .R7_q(R7_q), .Zlow_q(Zlow_q)
  );

  always #5 clock = ~clock;

  // out strobes: {MDR,Zlo,Zhi,PC,R7,R6,R1}
  localparam logic [6:0] O_NO  = 7'b0000000;
  localparam logic [6:0] O_MDR = 7'b1000000;
  localparam logic [6:0] O_ZLO = 7'b0100000;
  localparam logic [6:0] O_ZHI = 7'b0010000;
  localparam logic [6:0] O_PC  = 7'b0001000;
  localparam logic [6:0] O_R7  = 7'b0000100;
  localparam logic [6:0] O_R6  = 7'b0000010;
  localparam logic [6:0] O_R1  = 7'b0000001;
  // in strobes: {PC,IR,MAR,MDR,Y,Z,R1,R6,R7}
  localparam logic [8:0] L_NO  = 9'b000000000;
  localparam logic [8:0] L_PC  = 9'b100000000;
  localparam logic [8:0] L_IR  = 9'b010000000;
  localparam logic [8:0] L_MAR = 9'b001000000;
  localparam logic [8:0] L_MDR = 9'b000100000;
  localparam logic [8:0] L_Y   = 9'b000010000;
  localparam logic [8:0] L_Z   = 9'b000001000;
  localparam logic [8:0] L_R1  = 9'b000000100;
  localparam logic [8:0] L_R6  = 9'b000000010;
  localparam logic [8:0] L_R7  = 9'b000000001;
  // ops: {AND,IncPC}
  localparam logic [1:0] P_NO  = 2'b00;
  localparam logic [1:0] P_AND = 2'b10;
  localparam logic [1:0] P_INC = 2'b01;

  localparam logic [3:0] C_NO  = 4'd0;
  localparam logic [3:0] C_BUS = 4'd1;
  localparam logic [3:0] C_MAR = 4'd2;
  localparam logic [3:0] C_IR  = 4'd3;
  localparam logic [3:0] C_R1  = 4'd4;
  localparam logic [3:0] C_R6  = 4'd5;
  localparam logic [3:0] C_R7  = 4'd6;
  localparam logic [3:0] C_ZLO = 4'd7;

  typedef struct {
    logic [31:0] md;
    logic        rd;
    logic [6:0]  so;
    logic [8:0]  li;
    logic [1:0]  op;
    logic [3:0]  c1;
    logic [31:0] e1;
    logic [3:0]  c2;
    logic [31:0] e2;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, act, exp);
  endtask

  function automatic logic [31:0] get(input logic [3:0] id);
    case (id)
      C_BUS:   return BusMuxOut;
      C_MAR:   return MAR_q;
      C_IR:    return IR_q;
      C_R1:    return R1_q;
      C_R6:    return R6_q;
      C_R7:    return R7_q;
      C_ZLO:   return Zlow_q;
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] md, input logic rd,
                       input logic [6:0] so, input logic [8:0] li,
                       input logic [1:0] op);
    Mdatain = md;
    Read = rd;
    {MDRout, Zlowout, Zhighout, PCout, R7out, R6out, R1out} = so;
    {PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R6in, R7in} = li;
    {AND, IncPC} = op;
  endtask

  task automatic slot(input string nm, input logic [3:0] id,
                      input logic [31:0] e, input logic pre);
    if (id != C_NO && ((id == C_BUS) == pre))
      chk(nm, get(id), e);
  endtask

  task automatic apply(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    @(negedge clock);
    drive(vt[i].md, vt[i].rd, vt[i].so, vt[i].li, vt[i].op);
    #1;
    slot(nm, vt[i].c1, vt[i].e1, 1'b1);
    slot(nm, vt[i].c2, vt[i].e2, 1'b1);
    @(posedge clock);
    #1;
    slot(nm, vt[i].c1, vt[i].e1, 1'b0);
    slot(nm, vt[i].c2, vt[i].e2, 1'b0);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_bus"}, BusMuxOut, 32'h0);
    chk({nm, "_mar"}, MAR_q, 32'h0);
    chk({nm, "_ir"},  IR_q, 32'h0);
    chk({nm, "_r1"},  R1_q, 32'h0);
    chk({nm, "_r6"},  R6_q, 32'h0);
    chk({nm, "_r7"},  R7_q, 32'h0);
    chk({nm, "_zlo"}, Zlow_q, 32'h0);
  endtask

  initial begin
    vt[0]  = '{32'h12, 1, O_NO, L_MDR, P_NO, C_NO, 0, C_NO, 0};
    vt[1]  = '{32'h0, 0, O_MDR, L_R6, P_NO, C_R6, 32'h12, C_NO, 0};
    vt[2]  = '{32'h10, 1, O_NO, L_MDR, P_NO, C_NO, 0, C_NO, 0};
    vt[3]  = '{32'h0, 0, O_MDR, L_R7, P_NO, C_R7, 32'h10, C_NO, 0};
    vt[4]  = '{32'h18, 1, O_NO, L_MDR, P_NO, C_NO, 0, C_NO, 0};
    vt[5]  = '{32'h0, 0, O_MDR, L_R1, P_NO, C_R1, 32'h18, C_NO, 0};
    vt[6]  = '{32'h0, 0, O_PC, L_MAR, P_INC, C_MAR, 32'h0, C_ZLO, 32'h1};
    vt[7]  = '{32'h0, 0, O_ZLO, L_PC, P_NO, C_BUS, 32'h1, C_NO, 0};
    vt[8]  = '{32'h0, 0, O_PC, L_NO, P_NO, C_BUS, 32'h1, C_NO, 0};
    vt[9]  = '{32'h4, 1, O_NO, L_MDR, P_NO, C_NO, 0, C_NO, 0};
    vt[10] = '{32'h0, 0, O_MDR, L_IR, P_NO, C_IR, 32'h4, C_NO, 0};
    vt[11] = '{32'h0, 0, O_R7, L_Y, P_NO, C_BUS, 32'h10, C_NO, 0};
    vt[12] = '{32'h0, 0, O_R6, L_NO, P_AND, C_ZLO, 32'h10, C_NO, 0};
    vt[13] = '{32'h0, 0, O_ZLO, L_R6, P_NO, C_R6, 32'h10, C_R1, 32'h18};
    vt[14] = '{32'h0, 0, O_MDR | O_R7, L_NO, P_NO, C_BUS, 32'h4, C_NO, 0};
    vt[15] = '{32'h0, 0, O_NO, L_NO, P_NO, C_BUS, 32'h0, C_NO, 0};
    vt[16] = '{32'h0, 0, O_R7, L_R7, P_INC, C_R7, 32'h10, C_ZLO, 32'h11};
    vt[17] = '{32'h0, 0, O_R1, L_NO, P_AND | P_INC, C_ZLO, 32'h10, C_NO, 0};
    vt[18] = '{32'h0, 0, O_R1, L_Z, P_NO, C_ZLO, 32'h18, C_NO, 0};
    vt[19] = '{32'h0, 0, O_ZHI | O_R1, L_NO, P_NO, C_BUS, 32'h0, C_NO, 0};
    vt[20] = '{32'h0, 0, O_R6 | O_R1, L_NO, P_NO, C_BUS, 32'h10, C_NO, 0};
    vt[21] = '{32'hFFFFFFFF, 1, O_NO, L_MDR, P_NO, C_NO, 0, C_NO, 0};
    vt[22] = '{32'h0, 0, O_MDR, L_NO, P_INC, C_ZLO, 32'h0, C_NO, 0};
    vt[23] = '{32'hDEADBEEF, 0, O_R1, L_MDR, P_NO, C_NO, 0, C_NO, 0};
    vt[24] = '{32'h0, 0, O_MDR, L_NO, P_NO, C_BUS, 32'h18, C_NO, 0};
    vt[25] = '{32'h0, 0, O_ZLO | O_PC, L_NO, P_NO, C_BUS, 32'h0, C_NO, 0};
    vt[26] = '{32'h0, 0, O_PC | O_R7, L_NO, P_NO, C_BUS, 32'h1, C_NO, 0};

    // reset held while every load strobe is pulsed
    drive(32'hFFFFFFFF, 1, O_MDR, 9'h1FF, P_INC);
    step();
    step();
    chk_all_zero("rst_hold");
    @(negedge clock);
    drive(32'h0, 0, O_NO, L_NO, P_NO);
    clear = 1'b1;
    step();
    chk_all_zero("rst_rel");

    for (int i = 0; i < NV; i++) apply(i);

`ifdef DATAPATH_NEG_EN
    @(negedge clock);
    drive(32'h0, 0, O_R1, L_NO, P_NO);
    NEG = 1'b1;
    step();
    chk("neg", Zlow_q, 32'hFFFFFFE8);
    @(negedge clock);
    drive(32'h0, 0, O_R1, L_NO, P_AND);
    step();
    chk("neg_and", Zlow_q, 32'h10);
    @(negedge clock);
    drive(32'h0, 0, O_R1, L_NO, P_INC);
    step();
    chk("neg_inc", Zlow_q, 32'hFFFFFFE8);
    @(negedge clock);
    NEG = 1'b0;
`endif

    // clear asserted in the middle of an operation
    @(negedge clock);
    drive(32'h0, 0, O_R1, L_R6, P_INC);
    #2;
    clear = 1'b0;
    #1;
    chk("mid_r1", R1_q, 32'h0);
    chk("mid_bus", BusMuxOut, 32'h0);
    chk("mid_zlo", Zlow_q, 32'h0);
    step();
    chk("mid_r6", R6_q, 32'h0);
    @(negedge clock);
    clear = 1'b1;
    drive(32'h55, 1, O_NO, L_MDR, P_NO);
    step();
    @(negedge clock);
    drive(32'h0, 0, O_MDR, L_R7, P_NO);
    step();
    chk("post_r7", R7_q, 32'h55);
    @(negedge clock);
    drive(32'h0, 0, O_NO, L_NO, P_NO);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
